// File: rtl/run_controller_pkg.sv
// Shared types and width helpers for the run controller and its out-channel checker.
package run_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } runState_t;

  localparam int N_EXPECTED_DEF = 200;
  localparam int MAX_STEPS_DEF  = 256;
  localparam int ADDR_W_DEF     = $clog2(N_EXPECTED_DEF);
  localparam int IDX_W_DEF      = ADDR_W_DEF + 1;
  localparam int STEPS_W_DEF    = $clog2(MAX_STEPS_DEF + 1);

  // "No mismatch seen" marker at the default index width.
  localparam logic [IDX_W_DEF-1:0] NO_MISMATCH = {IDX_W_DEF{1'b1}};

  function automatic int idxWidth(input int nExpected);
    return $clog2(nExpected) + 1;
  endfunction

  function automatic int stepsWidth(input int maxSteps);
    return $clog2(maxSteps + 1);
  endfunction

endpackage

// File: rtl/run_controller_out_checker.sv
// Counts out-channel writes, compares each against the expected table and
// latches the index of the first bad or surplus write.
module out_checker
  import run_controller_pkg::*;
#(
  parameter  int MemoryElementWidth = 12,
  parameter  int NExpected          = N_EXPECTED_DEF,
  localparam int IdxW               = idxWidth(NExpected)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          enable,
  input  logic                          outValid,
  input  logic [MemoryElementWidth-1:0] outData,
  input  logic [MemoryElementWidth-1:0] expRdData,
  input  logic [IdxW-1:0]               expCount,
  output logic [IdxW-1:0]               outCount,
  output logic [IdxW-1:0]               mismatchIndex,
  output logic                          cleanNext
);

  localparam logic [IdxW-1:0] NoMismatch = {IdxW{1'b1}};
  localparam logic [IdxW-1:0] CountOne   = {{(IdxW-1){1'b0}}, 1'b1};

  logic [IdxW-1:0] countNext_s;
  logic [IdxW-1:0] mismatchNext_s;
  logic            fault_s;

  // Next count/first-fault values; the controller samples cleanNext so a
  // write landing in the halt cycle still counts toward success.
  always_comb begin
    countNext_s    = outCount;
    mismatchNext_s = mismatchIndex;
    fault_s        = (outCount >= expCount) || (outData != expRdData);
    if (enable && outValid) begin
      if (fault_s && (mismatchIndex == NoMismatch)) begin
        mismatchNext_s = outCount;
      end else begin
        mismatchNext_s = mismatchIndex;
      end
      if (outCount != NoMismatch) begin
        countNext_s = outCount + CountOne;
      end else begin
        countNext_s = outCount;
      end
    end else begin
      countNext_s    = outCount;
      mismatchNext_s = mismatchIndex;
    end
    cleanNext = (mismatchNext_s == NoMismatch) && (countNext_s == expCount);
  end

  // Counter and first-fault registers, cleared for each new run.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      outCount      <= {IdxW{1'b0}};
      mismatchIndex <= NoMismatch;
    end else begin
      outCount      <= countNext_s;
      mismatchIndex <= mismatchNext_s;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Starts the core, gates its per-step advance under a step budget and grades its output.
// Optional single-step/breakpoint control: define RUN_CONTROLLER_SINGLE_STEP_EN.
module run_controller
  import run_controller_pkg::*;
#(
  parameter  int MemoryElementWidth = 12,
  parameter  int IpWidth            = 12,
  parameter  int MaxSteps           = MAX_STEPS_DEF,
  parameter  int NExpected          = N_EXPECTED_DEF,
  localparam int AddrW              = $clog2(NExpected),
  localparam int IdxW               = idxWidth(NExpected),
  localparam int StepsW             = stepsWidth(MaxSteps)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  output logic                          step_en,
  input  logic [IpWidth-1:0]            core_ip,
  input  logic                          core_halt,
  input  logic                          out_valid,
  input  logic [MemoryElementWidth-1:0] out_data,
  output logic [AddrW-1:0]              exp_rd_addr,
  input  logic [MemoryElementWidth-1:0] exp_rd_data,
  input  logic [IdxW-1:0]               exp_count,
`ifdef RUN_CONTROLLER_SINGLE_STEP_EN
  input  logic                          step_req,
  input  logic [IpWidth-1:0]            break_ip,
  output logic                          at_ip,
`endif
  output logic                          core_init,
  output logic                          busy,
  output logic                          finished,
  output logic                          success,
  output logic                          timeout,
  output logic [StepsW-1:0]             steps,
  output logic [IdxW-1:0]               mismatch_index
);

  localparam logic [StepsW-1:0] StepBudget = StepsW'(MaxSteps);
  localparam logic [StepsW-1:0] StepOne    = {{(StepsW-1){1'b0}}, 1'b1};

  runState_t        state_r;
  logic             startPrev_r;
  logic             startRise_s;
  logic             budgetOk_s;
  logic             reqOk_s;
  logic             cleanNext_s;
  logic [IdxW-1:0]  outCount_s;

  assign startRise_s = start && !startPrev_r;
  assign budgetOk_s  = (steps != StepBudget);
  assign exp_rd_addr = outCount_s[AddrW-1:0];

`ifdef RUN_CONTROLLER_SINGLE_STEP_EN
  logic stepReqPrev_r;
  logic atIpPrev_r;
  logic parked_r;
  logic stepReqRise_s;
  logic hold_s;

  assign at_ip = (core_ip == break_ip);

  // Arriving at the breakpoint parks the core; only a fresh request moves it on.
  always_comb begin
    stepReqRise_s = step_req && !stepReqPrev_r;
    hold_s        = parked_r || (at_ip && !atIpPrev_r);
    if (hold_s) begin
      reqOk_s = stepReqRise_s;
    end else begin
      reqOk_s = step_req;
    end
  end

  // Request/breakpoint history, only meaningful while running.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stepReqPrev_r <= 1'b0;
      atIpPrev_r    <= 1'b0;
      parked_r      <= 1'b0;
    end else if (state_r != RUN) begin
      stepReqPrev_r <= step_req;
      atIpPrev_r    <= 1'b0;
      parked_r      <= 1'b0;
    end else begin
      stepReqPrev_r <= step_req;
      atIpPrev_r    <= at_ip;
      parked_r      <= hold_s && !stepReqRise_s;
    end
  end
`else
  logic unusedIp_s;
  assign unusedIp_s = ^core_ip;
  assign reqOk_s    = 1'b1;
`endif

  // Step grant reacts to halt and budget in the same cycle.
  always_comb begin
    if (state_r == RUN) begin
      step_en = !core_halt && budgetOk_s && reqOk_s;
    end else begin
      step_en = 1'b0;
    end
  end

  // Run sequencing with registered status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= IDLE;
      startPrev_r <= 1'b0;
      core_init   <= 1'b0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      success     <= 1'b0;
      timeout     <= 1'b0;
      steps       <= {StepsW{1'b0}};
    end else begin
      startPrev_r <= start;
      core_init   <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (startRise_s) begin
            state_r   <= INIT;
            core_init <= 1'b1;
            busy      <= 1'b1;
            finished  <= 1'b0;
            success   <= 1'b0;
            timeout   <= 1'b0;
            steps     <= {StepsW{1'b0}};
          end
        end
        INIT: begin
          state_r <= RUN;
          steps   <= {StepsW{1'b0}};
          timeout <= 1'b0;
        end
        RUN: begin
          if (step_en) begin
            steps <= steps + StepOne;
          end
          if (core_halt) begin
            state_r  <= DONE;
            busy     <= 1'b0;
            finished <= 1'b1;
            success  <= cleanNext_s;
          end else if (!budgetOk_s) begin
            state_r  <= DONE;
            busy     <= 1'b0;
            finished <= 1'b1;
            timeout  <= 1'b1;
            success  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  out_checker #(
    .MemoryElementWidth (MemoryElementWidth),
    .NExpected          (NExpected)
  ) u_outChecker (
    .clock         (clock),
    .reset         (reset),
    .clear         (state_r == INIT),
    .enable        (state_r == RUN),
    .outValid      (out_valid),
    .outData       (out_data),
    .expRdData     (exp_rd_data),
    .expCount      (exp_count),
    .outCount      (outCount_s),
    .mismatchIndex (mismatch_index),
    .cleanNext     (cleanNext_s)
  );

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: a model core walks ip 0..N, writing every 8th step.
module tb_run_controller;
  import run_controller_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        step_en;
  logic [11:0] core_ip;
  logic        core_halt;
  logic        out_valid;
  logic [11:0] out_data;
  logic [7:0]  exp_rd_addr;
  logic [11:0] exp_rd_data;
  logic [8:0]  exp_count;
  logic        core_init;
  logic        busy;
  logic        finished;
  logic        success;
  logic        timeout;
  logic [8:0]  steps;
  logic [8:0]  mismatch_index;

  logic [11:0] expTable [0:255];
  int          vectorCount = 0;
  int          missCount   = 0;

  int   ip, haltAt, nEmit, badIdx;
  logic lastAtHalt;
  int   tickCount, haltTick, doneTick, grantCount;
  logic finAtHalt, g, ci;

  always #5 clock = ~clock;

  assign exp_rd_data = expTable[exp_rd_addr];

  run_controller dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .step_en        (step_en),
    .core_ip        (core_ip),
    .core_halt      (core_halt),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .exp_rd_addr    (exp_rd_addr),
    .exp_rd_data    (exp_rd_data),
    .exp_count      (exp_count),
    .core_init      (core_init),
    .busy           (busy),
    .finished       (finished),
    .success        (success),
    .timeout        (timeout),
    .steps          (steps),
    .mismatch_index (mismatch_index)
  );

  task automatic checkVal(input string tag, input int actual, input int expected);
    vectorCount++;
    if (actual != expected) begin
      missCount++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic setRun(input int h, input int n, input int b, input logic l);
    haltAt = h; nEmit = n; badIdx = b; lastAtHalt = l;
  endtask

  // One clock of the model core: drive, sample mid-cycle, advance ip after the edge.
  task automatic tick();
    int   k;
    int   limit;
    logic v;
    v = 1'b0; k = 0;
    limit = lastAtHalt ? nEmit - 1 : nEmit;
    if (ip < haltAt) begin
      if ((ip % 8) == 0 && (ip / 8) < limit) begin
        v = 1'b1; k = ip / 8;
      end
    end else if (lastAtHalt && ip == haltAt) begin
      v = 1'b1; k = nEmit - 1;
    end
    out_valid = v;
    out_data  = (k == badIdx) ? 12'd7 : expTable[k];
    core_halt = (ip >= haltAt);
    core_ip   = 12'(ip);
    @(negedge clock); #1;
    g  = step_en;
    ci = core_init;
    if (core_halt && busy && !ci && haltTick < 0) begin
      haltTick  = tickCount;
      finAtHalt = finished;
    end
    @(posedge clock); #1;
    if (ci) ip = 0;
    else if (g) begin
      ip++;
      grantCount++;
    end
    if (finished && doneTick < 0) doneTick = tickCount;
    tickCount++;
  endtask

  task automatic startRun();
    haltTick = -1; doneTick = -1; grantCount = 0;
    start = 1'b1;
    tick();
    checkVal("core_init_pulse", core_init, 1);
    checkVal("busy_in_init", busy, 1);
    start = 1'b0;
    tick();
  endtask

  task automatic runUntilDone(input int maxCycles);
    int n;
    n = 0;
    while (!finished && n < maxCycles) begin
      tick();
      n++;
    end
    if (!finished) checkVal("done_bound", 0, 1);
  endtask

  initial begin
    int seqv [25] = '{1,3,5,9,10,2,4,5,9,10,2,4,5,9,10,2,4,6,8,10,2,4,5,7,8};
    for (int i = 0; i < 256; i++) expTable[i] = 12'd0;
    for (int i = 0; i < 25; i++) expTable[i] = 12'(seqv[i]);
    exp_count = 9'd25;
    ip = 0; tickCount = 0; haltTick = -1; doneTick = -1; grantCount = 0; finAtHalt = 1'b0;
    setRun(200, 25, -1, 1'b0);
    reset = 1'b0; start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    checkVal("rst_finished", finished, 0);
    checkVal("rst_busy", busy, 0);
    checkVal("rst_core_init", core_init, 0);
    checkVal("rst_steps", steps, 0);
    checkVal("rst_mismatch_index", mismatch_index, int'(NO_MISMATCH));
    checkVal("rst_step_en", step_en, 0);

    // Clean run
    startRun();
    runUntilDone(400);
    checkVal("clean_finished", finished, 1);
    checkVal("clean_success", success, 1);
    checkVal("clean_timeout", timeout, 0);
    checkVal("clean_mismatch_index", mismatch_index, 511);
    checkVal("clean_steps", steps, 200);
    checkVal("clean_grants", grantCount, 200);
    checkVal("clean_out_count", exp_rd_addr, 25);
    checkVal("clean_step_en_done", step_en, 0);

    // Wrong value at index 3
    setRun(200, 25, 3, 1'b0);
    startRun();
    runUntilDone(400);
    checkVal("bad3_success", success, 0);
    checkVal("bad3_mismatch_index", mismatch_index, 3);
    checkVal("bad3_steps", steps, 200);

    // Never halts: step budget
    setRun(100000, 25, -1, 1'b0);
    startRun();
    runUntilDone(600);
    checkVal("to_finished", finished, 1);
    checkVal("to_timeout", timeout, 1);
    checkVal("to_success", success, 0);
    checkVal("to_steps", steps, 256);
    checkVal("to_grants", grantCount, 256);
    checkVal("to_step_en", step_en, 0);

    // One write too many
    setRun(208, 26, -1, 1'b0);
    startRun();
    runUntilDone(400);
    checkVal("ovf_mismatch_index", mismatch_index, 25);
    checkVal("ovf_success", success, 0);
    checkVal("ovf_timeout", timeout, 0);

    // One write short
    setRun(200, 24, -1, 1'b0);
    startRun();
    runUntilDone(400);
    checkVal("short_mismatch_index", mismatch_index, 511);
    checkVal("short_success", success, 0);
    checkVal("short_out_count", exp_rd_addr, 24);

    // Reset mid-run, then a clean rerun
    setRun(200, 25, -1, 1'b0);
    startRun();
    for (int n = 0; n < 100 && ip < 50; n++) tick();
    checkVal("mid_reach_step50", ip, 50);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkVal("mid_rst_busy", busy, 0);
    checkVal("mid_rst_finished", finished, 0);
    checkVal("mid_rst_steps", steps, 0);
    checkVal("mid_rst_out_count", exp_rd_addr, 0);
    checkVal("mid_rst_mismatch_index", mismatch_index, 511);
    checkVal("mid_rst_step_en", step_en, 0);
    startRun();
    runUntilDone(400);
    checkVal("rerun_success", success, 1);
    checkVal("rerun_steps", steps, 200);

    // Last write lands in the halt cycle
    setRun(200, 25, -1, 1'b1);
    startRun();
    runUntilDone(400);
    checkVal("hw_success", success, 1);
    checkVal("hw_mismatch_index", mismatch_index, 511);
    checkVal("hw_finished_low_at_halt", finAtHalt, 0);
    checkVal("hw_halt_to_finished", doneTick - haltTick + 1, 1);
    tick(); tick(); tick();
    checkVal("hw_ignore_after_done", mismatch_index, 511);
    checkVal("hw_out_count_hold", exp_rd_addr, 25);
    checkVal("hw_finished_hold", finished, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Sequences one program-execution core, the case-on-ip engine that writes to an out channel.
- Starts the core, gates its per-step advance, and enforces a step budget.
- Checks every out-channel write against an expected-value table and reports finished/success.
- Sits between the board-level run button and the core; it replaces the free-running step toggle and the end-of-program success checks.

Parameters:
- MemoryElementWidth, 12, width of out-channel data and expected values
- IpWidth, 12, width of core instruction pointer
- MaxSteps, 256, step budget before timeout (must be >= 1)
- NExpected, 200, depth of expected table; sets the width of exp_count and exp_rd_addr

Ports:
- clock  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-low; sampled on rising edge of clock
- start  input  1  level, acted on at rising edge (0->1 seen in consecutive cycles)
- step_en  output  1  core advances one instruction in a cycle where high
- core_ip  input  IpWidth  core instruction pointer, observation only
- core_halt  input  1  core ip has left the program (default arm reached)
- out_valid  input  1  core wrote out channel this cycle
- out_data  input  MemoryElementWidth  value written
- exp_rd_addr  output  clog2(NExpected)  index of next expected value (= out_count)
- exp_rd_data  input  MemoryElementWidth  expected value, combinational from exp_rd_addr
- exp_count  input  clog2(NExpected)+1  number of valid expected entries
- core_init  output  1  one-cycle pulse that resets the core (ip=0, outMemPos=0)
- busy  output  1  high in INIT/RUN
- finished  output  1  high in DONE
- success  output  1  valid when finished
- timeout  output  1  budget exhausted, valid when finished
- steps  output  clog2(MaxSteps+1)  steps granted in the current run
- mismatch_index  output  clog2(NExpected)+1  first failing out index; all-ones if none

Behaviour:
- Reset (reset==0 at a clock edge), from any state including mid-run: state=IDLE; step_en=0, core_init=0, busy=0, finished=0, success=0, timeout=0, steps=0, out_count=0, mismatch_index=all-ones.
- States: IDLE, INIT, RUN, DONE (shared enum).
- IDLE: on start rising edge -> INIT.
- INIT: lasts one cycle; core_init=1; clear steps, out_count, timeout, mismatch_index; go to RUN. busy=1 from INIT entry.
- RUN: step_en=1 every cycle; steps++ per granted step.
  - Priority in one cycle: core_halt, then budget, then compare.
  - core_halt=1 -> DONE; step_en=0 that cycle.
  - A write in the same cycle as core_halt is still checked.
  - When steps==MaxSteps and no halt: step_en=0, timeout=1, go to DONE.
- Compare, on each out_valid in RUN:
  - If out_count >= exp_count (overflow) or out_data != exp_rd_data, and mismatch_index is all-ones, latch mismatch_index=out_count.
  - out_count++ in both cases, saturating at all-ones of its width.
- DONE: finished=1. success = !timeout && mismatch_index==all-ones && out_count==exp_count, registered on DONE entry.
  - Outputs hold until reset or a new start rising edge, which goes to INIT.
- start during INIT/RUN is ignored.
- out_valid outside RUN is ignored.
- Latency: start edge -> core_init 1 cycle; core_halt -> finished 1 cycle.

Optional Feature:
- RUN_CONTROLLER_SINGLE_STEP_EN.
- Defined: adds input step_req (1 bit). In RUN, step_en=step_req & !halt & budget-ok, so steps count only granted requests. Adds output at_ip (1 bit), high when core_ip equals the added input break_ip (IpWidth); at_ip also forces step_en=0 until the next step_req.
- Undefined: no extra ports; step_en free-runs as above.

Decomposition:
- Package run_controller_pkg: state enum (IDLE, INIT, RUN, DONE), the all-ones NO_MISMATCH constant, and width helper localparams from NExpected/MaxSteps.
- One sub-module, out_checker: holds out_count and mismatch_index, does compare/overflow/saturation, and has a clear input driven by INIT.

Test Plan:
- Expected table {1,3,5,9,10,2,4,5,9,10,2,4,5,9,10,2,4,6,8,10,2,4,5,7,8}, exp_count=25; model core emits the same and halts at step 200 -> finished=1, success=1, timeout=0, mismatch_index=all-ones, steps=200.
- Same table, core emits 7 in place of the 4th value (index 3) -> success=0, mismatch_index=3; run continues to halt.
- Core never halts, MaxSteps=256 -> step_en low after 256 grants, finished=1, timeout=1, success=0, steps=256.
- Core emits 26 values against exp_count=25 -> mismatch_index=25, success=0. Core emits 24 -> mismatch_index all-ones, success=0 (count short).
- reset low for one cycle at step 50 of a run -> next cycle all outputs at reset values. Then start -> core_init pulse, and a clean run gives success=1.
- core_halt and out_valid in the same cycle, with the last expected value -> value checked, success=1, finished one cycle later.
